// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl
// Brief    : Direct-mapped read cache with built-in line-refill FSM and
//            saturating hit/miss performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req,
  input  logic [ADDR_W-1:0]             cpu_addr,
  output logic                          cpu_ready,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_hit,
  input  logic                          flush,
  output logic                          mem_req,
  output logic [ADDR_W-OFFSET_W-1:0]    mem_addr,
  input  logic                          mem_ack,
  input  logic [(DATA_W<<OFFSET_W)-1:0] mem_rdata,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int LINE_W = DATA_W << OFFSET_W;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag_mem  [LINES];
  logic [LINE_W-1:0]   r_data_mem [LINES];

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_idx;
  logic [OFFSET_W-1:0] w_off;
  logic [LINE_W-1:0]   w_line;
  logic                w_hit;
  logic                w_fill;
  logic [DATA_W-1:0]   w_cache_word;
  logic [DATA_W-1:0]   w_mem_word;

  // Split the latched address and evaluate the tag match for the indexed line.
  always_comb begin
    w_tag        = r_addr[ADDR_W-1 -: TAG_W];
    w_idx        = r_addr[OFFSET_W +: INDEX_W];
    w_off        = r_addr[OFFSET_W-1:0];
    w_line       = r_data_mem[w_idx];
    w_hit        = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);
    w_fill       = (r_state == S_REFILL) && mem_ack;
    w_cache_word = w_line[w_off*DATA_W +: DATA_W];
    w_mem_word   = mem_rdata[w_off*DATA_W +: DATA_W];
  end

  // Tag/data arrays: unreset storage, written only when a refill completes.
  always_ff @(posedge clk) begin
    if (!rst && w_fill) begin
      r_tag_mem[w_idx]  <= w_tag;
      r_data_mem[w_idx] <= mem_rdata;
    end
  end

  // Control FSM, valid bits, CPU/memory outputs and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_valid    <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_hit    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Flush takes priority; a coincident request must be re-presented.
          if (flush) begin
            r_valid <= '0;
          end else if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            if (hit_count != '1) hit_count <= hit_count + C_CNT_ONE;
            cpu_rdata <= w_cache_word;
            cpu_hit   <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + C_CNT_ONE;
            mem_req  <= 1'b1;
            mem_addr <= {w_tag, w_idx};
            r_state  <= S_REFILL;
          end
        end
        S_REFILL: begin
          // Return the word straight from the bus rather than re-reading the array.
          if (mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            cpu_rdata      <= w_mem_word;
            cpu_hit        <= 1'b0;
            mem_req        <= 1'b0;
            r_state        <= S_RESP;
          end
        end
        S_RESP: begin
          cpu_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_cache_ctrl
// Brief    : Directed self-checking bench for dm_cache_ctrl with a response
//            scoreboard; a second instance with 2-bit counters shares stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [14:0]  cpu_addr;
  logic         cpu_ready, cpu_ready2;
  logic [31:0]  cpu_rdata, cpu_rdata2;
  logic         cpu_hit, cpu_hit2;
  logic         flush;
  logic         mem_req, mem_req2;
  logic [12:0]  mem_addr, mem_addr2;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic [15:0]  hit_count, miss_count;
  logic [1:0]   hit_count2, miss_count2;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb_q [$];

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  dm_cache_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready2), .cpu_rdata(cpu_rdata2), .cpu_hit(cpu_hit2),
    .flush(flush), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count2), .miss_count(miss_count2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] line, input logic [14:0] a);
    logic [1:0] off;
    off = a[1:0];
    return line[off*32 +: 32];
  endfunction

  // One CPU read. Acks the refill ack_dly cycles after mem_req is seen, optionally
  // keeps cpu_req high and/or pulses flush during the refill, then scores the response.
  task automatic access(input logic [14:0] a, input logic [127:0] line, input int ack_dly,
                        input logic hold_req, input logic flush_mid,
                        output int lat, output logic saw_mreq, output logic [12:0] seen_maddr,
                        output int ack_to_ready);
    int req_cyc, ack_lat;
    logic done;
    logic [32:0] exp;
    cpu_addr = a; cpu_req = 1'b1; mem_rdata = line;
    lat = 0; saw_mreq = 1'b0; seen_maddr = '0; req_cyc = 0; ack_lat = -1; done = 1'b0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (!hold_req) cpu_req = 1'b0;
      mem_ack = 1'b0;
      flush = 1'b0;
      if (cpu_ready) begin
        done = 1'b1;
      end else if (mem_req) begin
        if (!saw_mreq) seen_maddr = mem_addr;
        saw_mreq = 1'b1;
        req_cyc++;
        if (flush_mid && req_cyc == 1) flush = 1'b1;
        if (req_cyc == ack_dly) begin
          mem_ack = 1'b1;
          ack_lat = lat;
        end
      end
    end
    cpu_req = 1'b0; mem_ack = 1'b0; flush = 1'b0;
    ack_to_ready = (ack_lat < 0) ? -1 : lat - ack_lat;
    if (!done) chk("ready_timeout", 64'd0, 64'd1);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
      chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, exp[31:0]});
      chk("cpu_hit", {63'd0, cpu_hit}, {63'd0, exp[32]});
    end
  endtask

  logic [127:0] line_a, line_b, line_c, line_d;
  int           lat, a2r;
  logic         saw;
  logic [12:0]  maddr;

  initial begin
    line_a = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    line_b = {32'h1111_0013, 32'h1111_0012, 32'h1111_0011, 32'h1111_0010};
    line_c = {32'h2222_0023, 32'h2222_0022, 32'h2222_0021, 32'h2222_0020};
    line_d = {32'h3333_0033, 32'h3333_0032, 32'h3333_0031, 32'h3333_0030};
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cpu_ready", {63'd0, cpu_ready}, 64'd0);
    chk("rst_cpu_rdata", {32'd0, cpu_rdata}, 64'd0);
    chk("rst_cpu_hit", {63'd0, cpu_hit}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {51'd0, mem_addr}, 64'd0);
    chk("rst_counters", {32'd0, hit_count, miss_count}, 64'd0);

    // 1: cold miss on 0x0005
    sb_q.push_back({1'b0, word_of(line_a, 15'h0005)});
    access(15'h0005, line_a, 3, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t1_mem_req_seen", {63'd0, saw}, 64'd1);
    chk("t1_mem_addr", {51'd0, maddr}, 64'h0001);
    chk("t1_ack_to_ready", a2r, 2);
    chk("t1_miss_count", {48'd0, miss_count}, 64'd1);
    chk("t1_hit_count", {48'd0, hit_count}, 64'd0);

    // 2: hit on the same line
    sb_q.push_back({1'b1, word_of(line_a, 15'h0007)});
    access(15'h0007, line_a, 3, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t2_hit_latency", lat, 3);
    chk("t2_no_mem_req", {63'd0, saw}, 64'd0);
    chk("t2_hit_count", {48'd0, hit_count}, 64'd1);
    tick(); tick(); tick();
    chk("t2_rdata_hold", {32'd0, cpu_rdata}, 64'hDDDD_0003);
    chk("t2_hit_hold", {63'd0, cpu_hit}, 64'd1);

    // 3: conflict eviction
    sb_q.push_back({1'b0, word_of(line_b, 15'h1005)});
    access(15'h1005, line_b, 2, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t3_conflict_addr", {51'd0, maddr}, 64'h0401);
    sb_q.push_back({1'b0, word_of(line_a, 15'h0005)});
    access(15'h0005, line_a, 1, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t3_evicted_miss", {63'd0, saw}, 64'd1);
    chk("t3_miss_count", {48'd0, miss_count}, 64'd3);

    // 4: reset during refill, then a late ack
    cpu_addr = 15'h2009; cpu_req = 1'b1;
    tick(); cpu_req = 1'b0;
    tick();
    chk("t4_in_refill", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_mem_req_dropped", {63'd0, mem_req}, 64'd0);
    mem_rdata = line_c; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("t4_no_ready", {63'd0, cpu_ready}, 64'd0);
    chk("t4_counters_zero", {32'd0, hit_count, miss_count}, 64'd0);
    sb_q.push_back({1'b0, word_of(line_c, 15'h2009)});
    access(15'h2009, line_c, 2, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t4_reread_miss", {63'd0, saw}, 64'd1);

    // 5: flush in IDLE invalidates; flush during refill is ignored
    sb_q.push_back({1'b0, word_of(line_a, 15'h0005)});
    access(15'h0005, line_a, 1, 1'b0, 1'b0, lat, saw, maddr, a2r);
    flush = 1'b1; tick(); flush = 1'b0;
    sb_q.push_back({1'b0, word_of(line_a, 15'h0005)});
    access(15'h0005, line_a, 2, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t5_flush_miss", {63'd0, saw}, 64'd1);
    sb_q.push_back({1'b0, word_of(line_b, 15'h0009)});
    access(15'h0009, line_b, 3, 1'b0, 1'b1, lat, saw, maddr, a2r);
    sb_q.push_back({1'b1, word_of(line_a, 15'h0004)});
    access(15'h0004, line_a, 1, 1'b0, 1'b0, lat, saw, maddr, a2r);
    chk("t5_midflush_ignored", {63'd0, saw}, 64'd0);

    // 6: counter saturation on the 2-bit instance, and held request
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back({1'b1, word_of(line_b, 15'h000A)});
      access(15'h000A, line_b, 1, 1'b0, 1'b0, lat, saw, maddr, a2r);
    end
    chk("t6_hit_count", {48'd0, hit_count}, 64'd6);
    chk("t6_miss_count", {48'd0, miss_count}, 64'd4);
    chk("t6_sat_hit", {62'd0, hit_count2}, 64'd3);
    chk("t6_sat_miss", {62'd0, miss_count2}, 64'd3);
    sb_q.push_back({1'b0, word_of(line_d, 15'h3006)});
    access(15'h3006, line_d, 4, 1'b1, 1'b0, lat, saw, maddr, a2r);
    tick(); tick(); tick();
    chk("t6_held_req_once", {32'd0, hit_count, miss_count}, {32'd0, 16'd6, 16'd5});
    chk("t6_no_extra_ready", {63'd0, cpu_ready}, 64'd0);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
